lsu: RTL and testbench

Load/store unit for the RV32 core: the initiator side of the single-port data memory interface (request / we_re / word address / byte mask / write data, registered read data). It accepts one load or store at a time from the execute stage, builds the byte mask and lane-replicated write data, sequences the memory request, and sign- or zero-extends the returned read data. It sits between execute and the data memory instance.

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_load_ext.sv | 35 +++
 rtl/lsu.sv | 112 +++++++++++
 tb/tb_lsu.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 decoding,
// byte-mask generation, store-lane replication and the alignment test.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // funct3[1:0] access size; funct3[2] selects zero extension on loads
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam int         F3_UNSIGNED = 2;

  function automatic logic [3:0] mask_gen(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << lo;
      SZ_HALF: m = 4'b0011 << {lo[1], 1'b0};
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_rep(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      default: mis = |lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load result formatting: picks the addressed byte/half lane out of the memory
// word and sign- or zero-extends it to 32 bits.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        uns;

  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    result   = 32'h0;
    uns      = funct3[F3_UNSIGNED];
    case (addr_lo)
      2'd0:    byte_sel = data[7:0];
      2'd1:    byte_sel = data[15:8];
      2'd2:    byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase
    half_sel = addr_lo[1] ? data[31:16] : data[15:0];
    case (funct3[1:0])
      SZ_BYTE: result = {{24{~uns & byte_sel[7]}}, byte_sel};
      SZ_HALF: result = {{16{~uns & half_sel[15]}}, half_sel};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32 load/store unit driving a single-port word-addressed data memory.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses complete with rsp_err and no memory access.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // Request: transfers on a rising edge with req_valid && req_ready; no other handshake state.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_request,
  output logic              mem_we_re,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic [3:0]        mem_mask,
  input  logic [31:0]       mem_data_out,
  output logic [1:0]        state_dbg
);

  lsu_state_t  state, state_nx;
  logic        accept;
  logic        mis;
  logic        store_q;
  logic        err_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] ext_data;
  logic        unused_addr_hi;

  // Byte-address bits above the memory size wrap away.
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
  assign accept         = req_valid && req_ready;

`ifdef MISALIGN_TRAP_EN
  assign mis = misaligned(req_funct3[1:0], req_addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  lsu_load_ext u_load_ext (
    .data    (mem_data_out),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .result  (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_ISSUE;
      // A trapped access never touched memory, so there is nothing to wait for.
      ST_ISSUE: state_nx = (store_q || err_q) ? ST_RESP : ST_WAIT;
      ST_WAIT:  state_nx = ST_RESP;
      ST_RESP:  state_nx = accept ? ST_ISSUE : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE) || (state == ST_RESP);
    rsp_valid = (state == ST_RESP);
    state_dbg = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q     <= 1'b0;
      err_q       <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      mem_request <= 1'b0;
      mem_we_re   <= 1'b0;
      mem_address <= '0;
      mem_data_in <= 32'h0;
      mem_mask    <= 4'h0;
      rsp_rdata   <= 32'h0;
    end else begin
      if (accept) begin
        store_q     <= req_store;
        err_q       <= mis;
        funct3_q    <= req_funct3;
        addr_lo_q   <= req_addr[1:0];
        mem_request <= ~mis;
        mem_we_re   <= req_store;
        mem_address <= req_addr[ADDR_W+1:2];
        mem_data_in <= req_store ? store_rep(req_funct3[1:0], req_wdata) : 32'h0;
        mem_mask    <= (req_store && !mis) ? mask_gen(req_funct3[1:0], req_addr[1:0]) : 4'h0;
        rsp_rdata   <= 32'h0;
      end else if (state == ST_ISSUE) begin
        mem_request <= 1'b0;
      end
      if (state == ST_WAIT) rsp_rdata <= ext_data;
    end
  end

  assign rsp_err = err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a behavioural word memory answers the memory port,
// and hand-computed expectations are checked for each access.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_request;
  logic        mem_we_re;
  logic [7:0]  mem_address;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_mask;
  logic [31:0] mem_data_out;
  logic [1:0]  state_dbg;

  int checks;
  int failures;
  int rsp_count;

  logic [31:0] mem [0:255];

  lsu #(.ADDR_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_request  (mem_request),
    .mem_we_re    (mem_we_re),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_mask     (mem_mask),
    .mem_data_out (mem_data_out),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data memory: masked write, registered read
  always @(posedge clk) begin
    if (mem_request) begin
      if (mem_we_re) begin
        for (int i = 0; i < 4; i++)
          if (mem_mask[i]) mem[mem_address][8*i +: 8] <= mem_data_in[8*i +: 8];
      end else begin
        mem_data_out <= mem[mem_address];
      end
    end
  end

  always @(negedge clk) if (rsp_valid) rsp_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access from IDLE: checks the issued memory request, response timing and data.
  task automatic do_op(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic exp_req, input logic [7:0] exp_addr,
                       input logic [3:0] exp_mask, input logic [31:0] exp_din,
                       input int exp_n, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    check({tag, "_mreq"}, {31'b0, mem_request}, {31'b0, exp_req});
    check({tag, "_we"}, {31'b0, mem_we_re}, {31'b0, st});
    check({tag, "_maddr"}, {24'b0, mem_address}, {24'b0, exp_addr});
    check({tag, "_mask"}, {28'b0, mem_mask}, {28'b0, exp_mask});
    if (st) check({tag, "_din"}, mem_data_in, exp_din);
    n = 0;
    while (!rsp_valid && n < 8) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, "_rsp_cycle"}, n, exp_n);
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    @(negedge clk);
    check({tag, "_pulse"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  // Load abandoned by reset in ISSUE (stage 1) or WAIT (stage 2).
  task automatic abort_op(input string tag, input int stage);
    int c0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h30;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (stage == 2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check({tag, "_state"}, {30'b0, state_dbg}, stage);
    c0 = rsp_count;
    #1 rst_n = 1'b0;
    #1;
    check({tag, "_mreq_async"}, {31'b0, mem_request}, 32'd0);
    check({tag, "_state_async"}, {30'b0, state_dbg}, 32'd0);
    check({tag, "_ready_async"}, {31'b0, req_ready}, 32'd1);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check({tag, "_no_rsp"}, rsp_count, c0);
  endtask

  initial begin
    int c0;
    checks     = 0;
    failures   = 0;
    rsp_count  = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_state", {30'b0, state_dbg}, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", {31'b0, rsp_err}, 32'd0);
    check("rst_mreq", {31'b0, mem_request}, 32'd0);
    check("rst_we", {31'b0, mem_we_re}, 32'd0);
    check("rst_maddr", {24'b0, mem_address}, 32'd0);
    check("rst_din", mem_data_in, 32'h0);
    check("rst_mask", {28'b0, mem_mask}, 32'd0);

    // word store, byte store into top lane, read back
    do_op("sw10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 8'h04, 4'b1111, 32'hDEADBEEF, 1, 32'h0, 0);
    do_op("sb13", 1, 3'b000, 32'h13, 32'h000000A5, 1, 8'h04, 4'b1000, 32'hA5A5A5A5, 1, 32'h0, 0);
    do_op("lw10", 0, 3'b010, 32'h10, 32'h0,        1, 8'h04, 4'b0000, 32'h0, 2, 32'hA5ADBEEF, 0);

    // extension cases on 0x8001F0FF at word 0x08
    do_op("sw20", 1, 3'b010, 32'h20, 32'h8001F0FF, 1, 8'h08, 4'b1111, 32'h8001F0FF, 1, 32'h0, 0);
    do_op("lb20",  0, 3'b000, 32'h20, 32'h0, 1, 8'h08, 4'b0000, 32'h0, 2, 32'hFFFFFFFF, 0);
    do_op("lbu20", 0, 3'b100, 32'h20, 32'h0, 1, 8'h08, 4'b0000, 32'h0, 2, 32'h000000FF, 0);
    do_op("lh22",  0, 3'b001, 32'h22, 32'h0, 1, 8'h08, 4'b0000, 32'h0, 2, 32'hFFFF8001, 0);
    do_op("lhu22", 0, 3'b101, 32'h22, 32'h0, 1, 8'h08, 4'b0000, 32'h0, 2, 32'h00008001, 0);
    do_op("lb21",  0, 3'b000, 32'h21, 32'h0, 1, 8'h08, 4'b0000, 32'h0, 2, 32'hFFFFFFF0, 0);

`ifdef MISALIGN_TRAP_EN
    do_op("lh21_mis", 0, 3'b001, 32'h21, 32'h0, 0, 8'h08, 4'b0000, 32'h0, 1, 32'h0, 1);
    do_op("lw22_mis", 0, 3'b010, 32'h22, 32'h0, 0, 8'h08, 4'b0000, 32'h0, 1, 32'h0, 1);
`else
    do_op("lh21_mis", 0, 3'b001, 32'h21, 32'h0, 1, 8'h08, 4'b0000, 32'h0, 2, 32'hFFFFF0FF, 0);
    do_op("lw22_mis", 0, 3'b010, 32'h22, 32'h0, 1, 8'h08, 4'b0000, 32'h0, 2, 32'h8001F0FF, 0);
`endif

    // upper half store, then re-read
    do_op("sh22",   1, 3'b001, 32'h22, 32'h0000BEEF, 1, 8'h08, 4'b1100, 32'hBEEFBEEF, 1, 32'h0, 0);
    do_op("lw20",   0, 3'b010, 32'h20, 32'h0, 1, 8'h08, 4'b0000, 32'h0, 2, 32'hBEEFF0FF, 0);
    do_op("lhu20",  0, 3'b101, 32'h20, 32'h0, 1, 8'h08, 4'b0000, 32'h0, 2, 32'h0000F0FF, 0);

    // address bits above the memory wrap
    do_op("sw414",  1, 3'b010, 32'h414, 32'hCAFEBABE, 1, 8'h05, 4'b1111, 32'hCAFEBABE, 1, 32'h0, 0);
    do_op("sb415",  1, 3'b000, 32'h415, 32'h00000077, 1, 8'h05, 4'b0010, 32'h77777777, 1, 32'h0, 0);
    do_op("lw14",   0, 3'b010, 32'h14, 32'h0, 1, 8'h05, 4'b0000, 32'h0, 2, 32'hCAFE77BE, 0);

    // back-to-back store then load with req_valid held
    c0 = rsp_count;
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h30;
    req_wdata  = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    check("b2b_ready_issue", {31'b0, req_ready}, 32'd0);
    check("b2b_st_mreq", {31'b0, mem_request}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("b2b_ready_resp", {31'b0, req_ready}, 32'd1);
    check("b2b_st_rsp", {31'b0, rsp_valid}, 32'd1);
    req_store  = 1'b0;
    req_wdata  = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_ld_issue_state", {30'b0, state_dbg}, 32'd1);
    check("b2b_ld_ready", {31'b0, req_ready}, 32'd0);
    check("b2b_ld_mreq", {31'b0, mem_request}, 32'd1);
    check("b2b_ld_we", {31'b0, mem_we_re}, 32'd0);
    check("b2b_ld_no_rsp", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("b2b_wait_ready", {31'b0, req_ready}, 32'd0);
    check("b2b_wait_state", {30'b0, state_dbg}, 32'd2);
    @(posedge clk);
    @(negedge clk);
    check("b2b_ld_rsp", {31'b0, rsp_valid}, 32'd1);
    check("b2b_ld_rdata", rsp_rdata, 32'h11223344);
    @(posedge clk);
    @(negedge clk);
    check("b2b_idle", {31'b0, rsp_valid}, 32'd0);
    check("b2b_rsp_count", rsp_count - c0, 32'd2);

    // reset in the middle of a load, then a clean load
    abort_op("abort_issue", 1);
    abort_op("abort_wait", 2);
    do_op("lw30", 0, 3'b010, 32'h30, 32'h0, 1, 8'h0C, 4'b0000, 32'h0, 2, 32'h11223344, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
